// File: rtl/imem_arb_if.sv
// imem_arb_if: fetch request/response types and the arbiter's port bundle.
// The arbiter connects through the slave modport; requesters and memory drive the master side.
package core;
   typedef struct packed {
      logic [31:0] addr;
      logic        en;
   } inst_fetch_req_t;
   typedef struct packed {
      logic [31:0] data;
      logic        done;
   } inst_fetch_rsp_t;
endpackage

interface imem_arb_if;
   core::inst_fetch_req_t req0, req1, mem_req;
   core::inst_fetch_rsp_t rsp0, rsp1, mem_rsp;
   logic                  err0, err1;
   logic [1:0]            gnt;
   modport master (output req0, req1, mem_rsp, input rsp0, rsp1, err0, err1, mem_req, gnt);
   modport slave (input req0, req1, mem_rsp, output rsp0, rsp1, err0, err1, mem_req, gnt);
endinterface

// File: rtl/imem_arb.sv
// imem_arb: round-robin arbiter sharing one instruction memory between two fetch paths,
// with stale-response filtering, zero-bubble handoff and an optional timeout abort.
module imem_arb #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter bit TIMEOUT_EN     = 1'b1
) (
   input logic       clk,
   input logic       rst,
   imem_arb_if.slave bus
);
   localparam int W = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;
   state_t      state, state_n;
   logic        last_gnt, last_n;
   logic [31:0] addr_q, addr_n;
   logic [W-1:0] wait_cnt, cnt_n;
   logic        busy, x, done, fresh, tmo, fwd, fwd_done, c0, c1, win, go;
   assign busy = state != IDLE;
   assign x    = state == BUSY1;
   assign done = bus.mem_rsp.done;
   assign fresh = x ? bus.req1.en && bus.req1.addr == addr_q
                    : bus.req0.en && bus.req0.addr == addr_q;
   assign tmo = TIMEOUT_EN && busy && wait_cnt == W'(TIMEOUT_CYCLES - 1) && !done;
   assign fwd      = busy && fresh && (done || tmo);
   assign fwd_done = busy && fresh && done;
   // a requester whose response was just forwarded sits out the handoff arbitration
   assign c0  = bus.req0.en && !(fwd_done && !x);
   assign c1  = bus.req1.en && !(fwd_done && x);
   assign win = c0 && c1 ? !last_gnt : c1;
   assign go  = (!busy || done) && (c0 || c1);
   always_comb begin
      state_n = go ? (win ? BUSY1 : BUSY0) : (!busy || done || tmo) ? IDLE : state;
      addr_n  = go ? (win ? bus.req1.addr : bus.req0.addr) : addr_q;
      last_n  = go ? win : last_gnt;
      cnt_n   = go ? '0 : (busy && wait_cnt != '1) ? wait_cnt + 1'b1 : wait_cnt;
   end
   always_ff @(posedge clk)
      if (!rst) begin
         state    <= IDLE;
         last_gnt <= 1'b1;
         addr_q   <= '0;
         wait_cnt <= '0;
      end else begin
         state    <= state_n;
         last_gnt <= last_n;
         addr_q   <= addr_n;
         wait_cnt <= cnt_n;
      end
   assign bus.gnt     = rst ? {x, state == BUSY0} : 2'b00;
   assign bus.mem_req = '{addr: rst ? addr_q : '0, en: rst && busy};
   assign bus.rsp0    = '{data: rst && fwd_done && !x ? bus.mem_rsp.data : '0, done: rst && fwd && !x};
   assign bus.rsp1    = '{data: rst && fwd_done && x ? bus.mem_rsp.data : '0, done: rst && fwd && x};
   assign bus.err0    = rst && fwd && tmo && !x;
   assign bus.err1    = rst && fwd && tmo && x;
endmodule

// File: tb/tb_imem_arb.sv
// tb_imem_arb: directed bench for imem_arb; expected responses are queued when the
// memory is driven and must appear on the matching rsp port in that same cycle.
module tb_imem_arb;
   logic clk, rst;
   int   checks = 0, errors = 0;
   typedef struct {
      logic        who;
      logic [31:0] data;
      logic        err;
   } exp_t;
   exp_t q[$];

   imem_arb_if bus ();
   imem_arb #(.TIMEOUT_CYCLES(4), .TIMEOUT_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sb();
      exp_t e;
      if (bus.rsp0.done || bus.rsp1.done) begin
         chk("rsp_expected", 32'(q.size() != 0), 1);
         chk("rsp_both", 32'(bus.rsp0.done && bus.rsp1.done), 0);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("rsp_who", 32'(bus.rsp1.done), 32'(e.who));
            chk("rsp_data", e.who ? bus.rsp1.data : bus.rsp0.data, e.data);
            chk("rsp_other_data", e.who ? bus.rsp0.data : bus.rsp1.data, 0);
            chk("rsp_err", 32'(e.who ? bus.err1 : bus.err0), 32'(e.err));
         end
      end else begin
         chk("rsp_missing", 32'(q.size()), 0);
         chk("rsp_idle_data", bus.rsp0.data | bus.rsp1.data, 0);
         chk("err_without_done", 32'(bus.err0 | bus.err1), 0);
         q.delete();
      end
   endtask

   task automatic settle();
      @(negedge clk);
      sb();
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      bus.req0 = '0;
      bus.req1 = '0;
      bus.mem_rsp = '0;
      adv();
      adv();
      // outputs held at zero while reset is asserted, even with live inputs
      bus.req0 = '{addr: 32'h100, en: 1'b1};
      bus.mem_rsp = '{data: 32'h5, done: 1'b1};
      settle();
      chk("rst_gnt", 32'(bus.gnt), 0);
      chk("rst_mem_en", 32'(bus.mem_req.en), 0);
      chk("rst_mem_addr", bus.mem_req.addr, 0);
      adv();
      // single request, done on the 4th busy cycle (also the timeout cycle: done wins)
      rst = 1'b1;
      bus.mem_rsp = '0;
      settle();
      chk("single_idle_gnt", 32'(bus.gnt), 0);
      chk("single_idle_en", 32'(bus.mem_req.en), 0);
      adv();
      settle();
      chk("single_c1_en", 32'(bus.mem_req.en), 1);
      chk("single_c1_addr", bus.mem_req.addr, 32'h100);
      chk("single_c1_gnt", 32'(bus.gnt), 1);
      adv();
      settle();
      adv();
      settle();
      adv();
      bus.mem_rsp = '{data: 32'hDEADBEEF, done: 1'b1};
      q.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
      settle();
      chk("single_c4_gnt", 32'(bus.gnt), 1);
      chk("single_c4_addr", bus.mem_req.addr, 32'h100);
      adv();
      bus.mem_rsp = '0;
      bus.req0.en = 1'b0;
      settle();
      chk("single_c5_gnt", 32'(bus.gnt), 0);
      chk("single_c5_en", 32'(bus.mem_req.en), 0);
      adv();
      // tie after reset: alternate 0,1,0,1 with no idle cycle between grants
      rst = 1'b0;
      adv();
      rst = 1'b1;
      bus.req0 = '{addr: 32'h100, en: 1'b1};
      bus.req1 = '{addr: 32'h200, en: 1'b1};
      settle();
      chk("tie_idle_gnt", 32'(bus.gnt), 0);
      adv();
      for (int i = 0; i < 4; i++) begin
         bus.mem_rsp = '{data: 32'(32'hA0 + i), done: 1'b1};
         if (i == 3) bus.req0.en = 1'b0;
         q.push_back('{i[0], 32'(32'hA0 + i), 1'b0});
         settle();
         chk("tie_gnt", 32'(bus.gnt), i[0] ? 2 : 1);
         chk("tie_addr", bus.mem_req.addr, i[0] ? 32'h200 : 32'h100);
         chk("tie_en", 32'(bus.mem_req.en), 1);
         adv();
      end
      bus.mem_rsp = '0;
      bus.req1.en = 1'b0;
      settle();
      chk("tie_end_gnt", 32'(bus.gnt), 0);
      adv();
      // address changes while granted: memory address held, response discarded, re-grant
      bus.req0 = '{addr: 32'h400, en: 1'b1};
      settle();
      adv();
      bus.req0.addr = 32'h404;
      settle();
      chk("chg_addr_held", bus.mem_req.addr, 32'h400);
      adv();
      bus.mem_rsp = '{data: 32'h11, done: 1'b1};
      settle();
      chk("chg_stale_err", 32'(bus.err0), 0);
      adv();
      bus.mem_rsp = '{data: 32'h22, done: 1'b1};
      q.push_back('{1'b0, 32'h22, 1'b0});
      settle();
      chk("chg_regrant_gnt", 32'(bus.gnt), 1);
      chk("chg_regrant_addr", bus.mem_req.addr, 32'h404);
      adv();
      bus.mem_rsp = '0;
      bus.req0.en = 1'b0;
      settle();
      chk("chg_end_gnt", 32'(bus.gnt), 0);
      adv();
      // stale drop: req1 withdraws one cycle before done
      bus.req1 = '{addr: 32'h300, en: 1'b1};
      settle();
      adv();
      settle();
      chk("stale_gnt", 32'(bus.gnt), 2);
      adv();
      bus.req1.en = 1'b0;
      settle();
      adv();
      bus.mem_rsp = '{data: 32'h77, done: 1'b1};
      settle();
      chk("stale_done", 32'(bus.rsp1.done), 0);
      chk("stale_err", 32'(bus.err1), 0);
      adv();
      bus.mem_rsp = '0;
      settle();
      chk("stale_end_gnt", 32'(bus.gnt), 0);
      adv();
      // timeout: silent memory, abort on the 4th busy cycle
      bus.req0 = '{addr: 32'h500, en: 1'b1};
      settle();
      adv();
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("tmo_wait_gnt", 32'(bus.gnt), 1);
         adv();
      end
      q.push_back('{1'b0, 32'h0, 1'b1});
      settle();
      chk("tmo_err0", 32'(bus.err0), 1);
      chk("tmo_gnt", 32'(bus.gnt), 1);
      adv();
      bus.req0.en = 1'b0;
      settle();
      chk("tmo_after_en", 32'(bus.mem_req.en), 0);
      chk("tmo_after_gnt", 32'(bus.gnt), 0);
      adv();
      // reset mid-transaction with done pending, then req0 wins the tie
      bus.req1 = '{addr: 32'h600, en: 1'b1};
      settle();
      adv();
      settle();
      chk("rmid_gnt", 32'(bus.gnt), 2);
      adv();
      rst = 1'b0;
      bus.req0 = '{addr: 32'h100, en: 1'b1};
      bus.mem_rsp = '{data: 32'h99, done: 1'b1};
      settle();
      chk("rmid_rst_gnt", 32'(bus.gnt), 0);
      chk("rmid_rst_done", 32'(bus.rsp1.done), 0);
      adv();
      rst = 1'b1;
      bus.mem_rsp = '0;
      settle();
      chk("rmid_after_gnt", 32'(bus.gnt), 0);
      chk("rmid_after_en", 32'(bus.mem_req.en), 0);
      adv();
      bus.req1.en = 1'b0;
      bus.mem_rsp = '{data: 32'h55, done: 1'b1};
      q.push_back('{1'b0, 32'h55, 1'b0});
      settle();
      chk("rmid_tie_gnt", 32'(bus.gnt), 1);
      adv();
      bus.req0.en = 1'b0;
      bus.mem_rsp = '0;
      settle();
      chk("rmid_end_gnt", 32'(bus.gnt), 0);
      chk("sb_empty", 32'(q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
